// File: rtl/force_pkg.sv
// Shared definitions for the force measurement chain: ADC controller,
// sample averager and UART framer all import this package.
package force_pkg;

    // Default ADC sample width and averaging window (N = 2**LOG2_N samples)
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LOG2_N = 4;

    // Accumulator width sized so a full window of maximum samples cannot overflow
    localparam int ACC_W = DEF_DATA_W + DEF_LOG2_N;

    // Any sample at or above this code marks its window as overloaded
    localparam logic [DEF_DATA_W-1:0] DEF_OVL_THRESH = 16'hFFF0;

    // Tare capture sequencing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        CAPT = 2'd2
    } tare_state_t;

endpackage

// File: rtl/force_sample_avg_if.sv
// Sample input strobe and result valid/ready channel of the force averager.
// The averager takes the slave side; whoever feeds samples and drains
// results takes the master side.
interface force_sample_avg_if #(
    parameter int DATA_W = force_pkg::DEF_DATA_W
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W:0]   m_data;
    logic              m_ovl;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output m_valid,
        output m_data,
        output m_ovl
    );

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  m_valid,
        input  m_data,
        input  m_ovl
    );
endinterface

// File: rtl/force_sample_avg_window_accum.sv
// Fixed-window accumulator: sums 2**LOG2_N samples, tracks overload across
// the window and emits the truncated mean as a one-cycle registered pulse.
// The window restarts with no gap, so back-to-back samples are never lost.
module window_accum
    import force_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                LOG2_N     = DEF_LOG2_N,
    parameter logic [DATA_W-1:0] OVL_THRESH = DEF_OVL_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              cnt_zero,
    output logic              win_done,
    output logic [DATA_W-1:0] win_mean,
    output logic              win_ovl
);

    localparam int SUM_W = DATA_W + LOG2_N;

    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  acc_next;
    logic [LOG2_N-1:0] cnt;
    logic              ovl;
    logic              ovl_next;

    // Running sum and overload OR including the sample presented this cycle
    always_comb begin
        acc_next = acc + SUM_W'(s_data);
        ovl_next = ovl | (s_data >= OVL_THRESH);
    end

    // Accumulate samples; on the last one of a window register the mean and restart
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            ovl      <= 1'b0;
            win_done <= 1'b0;
            win_mean <= '0;
            win_ovl  <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (s_valid) begin
                if (&cnt) begin
                    win_done <= 1'b1;
                    win_mean <= acc_next[SUM_W-1:LOG2_N];
                    win_ovl  <= ovl_next;
                    acc      <= '0;
                    cnt      <= '0;
                    ovl      <= 1'b0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    ovl <= ovl_next;
                end
            end
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/force_sample_avg.sv
// Force sample averager: windows ADC results, subtracts a captured tare
// offset and offers a signed force value on a valid/ready channel. Results
// arriving while the previous one is still unaccepted are dropped and counted.
module force_sample_avg
    import force_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                LOG2_N     = DEF_LOG2_N,
    parameter logic [DATA_W-1:0] OVL_THRESH = DEF_OVL_THRESH
) (
    input  logic                    clk,
    input  logic                    rst,
    force_sample_avg_if.slave       bus,
    input  logic                    tare_req,
    output logic                    tare_busy,
    output logic [7:0]              drop_cnt
);

    logic              cnt_zero;
    logic              win_done;
    logic [DATA_W-1:0] win_mean;
    logic              win_ovl;

    tare_state_t       state;
    tare_state_t       state_next;
    logic [DATA_W-1:0] tare;

    logic              new_result;
    logic [DATA_W:0]   result_data;

    logic              out_valid;
    logic [DATA_W:0]   out_data;
    logic              out_ovl;

    window_accum #(
        .DATA_W     (DATA_W),
        .LOG2_N     (LOG2_N),
        .OVL_THRESH (OVL_THRESH)
    ) u_window_accum (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (bus.s_valid),
        .s_data   (bus.s_data),
        .cnt_zero (cnt_zero),
        .win_done (win_done),
        .win_mean (win_mean),
        .win_ovl  (win_ovl)
    );

    // Tare state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Tare sequencing: wait for a clean window start, then swallow one window as tare
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tare_req) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (cnt_zero) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                if (win_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tare_busy   = (state != IDLE);
    assign new_result  = win_done && (state != CAPT);
    assign result_data = {1'b0, win_mean} - {1'b0, tare};

    // Tare register takes the mean of the captured window
    always_ff @(posedge clk) begin
        if (rst) begin
            tare <= '0;
        end else if ((state == CAPT) && win_done) begin
            tare <= win_mean;
        end
    end

    // Output holding register: load when free or being drained, otherwise drop and count
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovl   <= 1'b0;
            drop_cnt  <= '0;
        end else if (new_result) begin
            if (!out_valid || bus.m_ready) begin
                out_valid <= 1'b1;
                out_data  <= result_data;
                out_ovl   <= win_ovl;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (out_valid && bus.m_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.m_valid = out_valid;
    assign bus.m_data  = out_data;
    assign bus.m_ovl   = out_ovl;

endmodule

// File: tb/tb_force_sample_avg.sv
// Self-checking bench for force_sample_avg: each driven window pushes its
// expected result onto a queue and a monitor pops and compares it whenever
// the DUT hands a result downstream.
module tb_force_sample_avg;
    import force_pkg::*;

    typedef struct packed {
        logic [16:0] data;
        logic        ovl;
    } result_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tare_req;
    logic        tare_busy;
    logic [7:0]  drop_cnt;

    result_t     exp_q[$];
    result_t     mon_r;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] tare_exp = 16'd0;

    force_sample_avg_if #(.DATA_W(16)) bus ();

    force_sample_avg dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .tare_req  (tare_req),
        .tare_busy (tare_busy),
        .drop_cnt  (drop_cnt)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one run of samples back-to-back and push the expected result
    task automatic applyStimulus(input logic [15:0] value, input int count, input int ovl_pos,
                                 input bit alternate, input int tare_at, input bit expect_out);
        int          sum;
        bit          ovl;
        logic [15:0] smp;
        logic [15:0] mean;
        result_t     r;
        sum = 0;
        ovl = 1'b0;
        for (int i = 0; i < count; i++) begin
            if (alternate) begin
                smp = (i % 2 == 1) ? value : 16'd0;
            end else if (i == ovl_pos) begin
                smp = DEF_OVL_THRESH;
            end else begin
                smp = value;
            end
            sum += int'(smp);
            if (smp >= 16'hFFF0) ovl = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_data  = smp;
            tare_req    = (i == tare_at);
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        tare_req    = 1'b0;
        if (expect_out) begin
            mean   = 16'(sum >> 4);
            r.data = {1'b0, mean} - {1'b0, tare_exp};
            r.ovl  = ovl;
            exp_q.push_back(r);
        end
    endtask

    // Synchronous reset for a number of cycles
    task automatic applyReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Bounded wait for all pending expected results to be consumed
    task automatic waitDrain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each accepted result against the queue head
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", exp_q.size(), 1);
            end else begin
                mon_r = exp_q.pop_front();
                checkOutput("m_data", 32'(bus.m_data), 32'(mon_r.data));
                checkOutput("m_ovl", 32'(bus.m_ovl), 32'(mon_r.ovl));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        rst         = 1'b1;
        tare_req    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'd0;
        bus.m_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_valid", 32'(bus.m_valid), 0);
        checkOutput("rst_m_data", 32'(bus.m_data), 0);
        checkOutput("rst_m_ovl", 32'(bus.m_ovl), 0);
        checkOutput("rst_tare_busy", 32'(tare_busy), 0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] constant window and latency");
        applyStimulus(16'd1000, 16, -1, 1'b0, -1, 1'b1);
        @(negedge clk);
        checkOutput("latency_not_early", 32'(bus.m_valid), 0);
        @(negedge clk);
        checkOutput("latency_valid", 32'(bus.m_valid), 1);
        @(negedge clk);
        checkOutput("single_pulse", 32'(bus.m_valid), 0);
        waitDrain("drain_const");

        $display("[TB] tare capture");
        tare_req = 1'b1;
        @(posedge clk);
        #1;
        tare_req = 1'b0;
        @(negedge clk);
        checkOutput("tare_busy_pend", 32'(tare_busy), 1);
        @(posedge clk);
        #1;
        applyStimulus(16'd1000, 16, -1, 1'b0, -1, 1'b0);
        @(negedge clk);
        checkOutput("tare_busy_capt", 32'(tare_busy), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("tare_busy_done", 32'(tare_busy), 0);
        tare_exp = 16'd1000;
        @(posedge clk);
        #1;
        applyStimulus(16'd1200, 16, -1, 1'b0, -1, 1'b1);
        waitDrain("drain_tare_pos");
        applyStimulus(16'd500, 16, -1, 1'b0, -1, 1'b1);
        waitDrain("drain_tare_neg");

        $display("[TB] tare request mid-window");
        applyReset(2);
        tare_exp = 16'd0;
        applyStimulus(16'd800, 16, -1, 1'b0, 5, 1'b1);
        waitDrain("drain_mid_normal");
        applyStimulus(16'd800, 16, -1, 1'b0, -1, 1'b0);
        tare_exp = 16'd800;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(16'd800, 16, -1, 1'b0, -1, 1'b1);
        waitDrain("drain_mid_zero");

        $display("[TB] backpressure");
        applyReset(2);
        tare_exp    = 16'd0;
        bus.m_ready = 1'b0;
        applyStimulus(16'd100, 16, -1, 1'b0, -1, 1'b1);
        applyStimulus(16'd200, 16, -1, 1'b0, -1, 1'b0);
        applyStimulus(16'd300, 16, -1, 1'b0, -1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("bp_hold_valid", 32'(bus.m_valid), 1);
        checkOutput("bp_hold_data", 32'(bus.m_data), 100);
        checkOutput("bp_drop_cnt", 32'(drop_cnt), 2);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_valid_clear", 32'(bus.m_valid), 0);
        waitDrain("drain_bp");

        $display("[TB] overload and truncation");
        applyStimulus(16'd300, 16, 7, 1'b0, -1, 1'b1);
        waitDrain("drain_ovl");
        applyStimulus(16'd300, 16, -1, 1'b0, -1, 1'b1);
        waitDrain("drain_clean");
        applyStimulus(16'd1, 16, -1, 1'b1, -1, 1'b1);
        waitDrain("drain_trunc");

        $display("[TB] reset mid-window");
        applyStimulus(16'd5000, 8, -1, 1'b0, -1, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd5000;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        applyStimulus(16'd42, 16, -1, 1'b0, -1, 1'b1);
        waitDrain("drain_rst_mid");
        checkOutput("rst_mid_drop_cnt", 32'(drop_cnt), 0);

        $display("[TB] drop counter saturation");
        bus.m_ready = 1'b0;
        applyStimulus(16'd7, 16, -1, 1'b0, -1, 1'b1);
        for (int w = 0; w < 260; w++) begin
            applyStimulus(16'd9, 16, -1, 1'b0, -1, 1'b0);
        end
        repeat (3) @(negedge clk);
        checkOutput("drop_saturate", 32'(drop_cnt), 255);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        waitDrain("drain_sat");

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
